// File: rtl/seg7_bcd_scan_driver.sv
// seg7_bcd_scan_driver
//   Converts a 14-bit binary value to four BCD digits, one double-dabble
//   iteration per clock. It then time-multiplexes those digits onto a
//   4-digit common-anode display. The digit code feeds a separate
//   4-bit-to-7-segment decoder. Code 4'hF is the blank code.
//
// Parameters
//   SCAN_DIV   : clock cycles each digit is held before advancing (>= 2)
//   CONV_STEPS : double-dabble iterations, equal to the width of value_in
//
// Ports
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   value_in   in   binary value to display (0..9999 valid)
//   load       in   single-cycle strobe, sampled only while busy = 0
//   busy       out  conversion in progress
//   overflow   out  displayed value came from value_in > 9999
//   digit_code out  BCD code of the enabled digit
//   digit_sel  out  index of the enabled digit, 0 = rightmost
//   an         out  active-low anode enables, an[i] low when digit_sel = i
//
// Configuration macro
//   SEG7_LEADING_ZERO_BLANK_EN : when defined, digits above the most
//   significant nonzero digit are blanked at commit. Digit 0 is always shown.
//
// Handshake: load is a one-cycle request. It is accepted only on a clock
// edge where busy = 0. A load while busy = 1 is dropped, not queued.
// busy rises the cycle after acceptance and falls in the cycle the new
// digits are committed.

module seg7_bcd_scan_driver #(
    parameter int SCAN_DIV   = 100000,
    parameter int CONV_STEPS = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CONV_STEPS-1:0] value_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  overflow,
    output logic [3:0]            digit_code,
    output logic [1:0]            digit_sel,
    output logic [3:0]            an
);

    localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int ITER_W = $clog2(CONV_STEPS + 1);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_CONVERT = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [CONV_STEPS-1:0] bin_q, bin_d;
    logic [15:0]           bcd_q, bcd_d;
    logic [15:0]           bcd_adj, bcd_next;
    logic [ITER_W-1:0]     iter_q, iter_d;
    logic                  over_q, over_d;
    logic [15:0]           digits_q, digits_d;
    logic                  ovf_q, ovf_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            sel_q, sel_d;
    logic [3:0]            an_q, an_d;
    logic [3:0]            code_q, code_d;

    // Final digit pattern written at commit. When over is set, the pattern is all blank.
    function automatic logic [15:0] commit_digits(input logic [15:0] bcd, input logic over);
        logic [15:0] r;
        r = bcd;
        if (over) begin
            r = 16'hFFFF;
        end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        else begin
            if (bcd[15:12] == 4'd0) r[15:12] = 4'hF;
            if (bcd[15:8]  == 8'd0) r[11:8]  = 4'hF;
            if (bcd[15:4]  == 12'd0) r[7:4]  = 4'hF;
        end
`endif
        return r;
    endfunction

    // One double-dabble step: add 3 to each nibble >= 5, then shift in the binary MSB.
    // Only four digits are kept. For inputs > 9999 the top carry is lost,
    // but those results are blanked anyway.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[14:0], bin_q[CONV_STEPS-1]};
    end

    // Conversion FSM
    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        iter_d   = iter_q;
        over_d   = over_q;
        digits_d = digits_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    bin_d   = value_in;
                    bcd_d   = 16'd0;
                    iter_d  = '0;
                    over_d  = (32'(value_in) > 32'd9999);
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                bin_d  = bin_q << 1;
                bcd_d  = bcd_next;
                iter_d = iter_q + 1'b1;
                // The last iteration commits the result directly. The shown digits
                // change only here, so no partial result is ever displayed.
                if (iter_q == ITER_W'(CONV_STEPS - 1)) begin
                    digits_d = commit_digits(bcd_next, over_q);
                    ovf_d    = over_q;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scan: free-running dwell counter and digit select.
    // an/digit_code are registered from the next select value, so all three
    // outputs change on the same edge.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        sel_d = sel_q;
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            sel_d = sel_q + 2'd1;
        end
        an_d   = ~(4'b0001 << sel_d);
        code_d = digits_q[{sel_d, 2'b00} +: 4];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            bin_q    <= '0;
            bcd_q    <= 16'd0;
            iter_q   <= '0;
            over_q   <= 1'b0;
            digits_q <= 16'd0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            sel_q    <= 2'd0;
            an_q     <= 4'b1110;
            code_q   <= 4'h0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            iter_q   <= iter_d;
            over_q   <= over_d;
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            an_q     <= an_d;
            code_q   <= code_d;
        end
    end

    assign busy       = (state_q == S_CONVERT);
    assign overflow   = ovf_q;
    assign digit_code = code_q;
    assign digit_sel  = sel_q;
    assign an         = an_q;

endmodule

// File: tb/tb_seg7_bcd_scan_driver.sv
// Bench for seg7_bcd_scan_driver with SCAN_DIV = 4.
// The reference model computes the display digits from the decimal value
// with plain arithmetic. It computes the scan slot from the count of clock
// edges since the last reset.
// Inputs are driven at the falling edge, and outputs are sampled at the falling edge.

module tb_seg7_bcd_scan_driver;

    localparam int SCAN_DIV   = 4;
    localparam int CONV_STEPS = 14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] value_in = 14'd0;
    logic        load = 1'b0;
    logic        busy;
    logic        overflow;
    logic [3:0]  digit_code;
    logic [1:0]  digit_sel;
    logic [3:0]  an;

    int errors = 0;
    int checks = 0;
    int n_edges = 0;

    logic [3:0] exp_dig [4];
    logic       exp_ovf;

    seg7_bcd_scan_driver #(
        .SCAN_DIV   (SCAN_DIV),
        .CONV_STEPS (CONV_STEPS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .load       (load),
        .busy       (busy),
        .overflow   (overflow),
        .digit_code (digit_code),
        .digit_sel  (digit_sel),
        .an         (an)
    );

    // Clock / reset-relative edge count
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) n_edges <= 0;
        else        n_edges <= n_edges + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

    // Reference model: the digits the display should show after converting v
    function automatic void model_commit(input int v);
        if (v > 9999) begin
            for (int i = 0; i < 4; i++) exp_dig[i] = 4'hF;
            exp_ovf = 1'b1;
        end else begin
            exp_ovf    = 1'b0;
            exp_dig[0] = 4'(v % 10);
            exp_dig[1] = 4'((v / 10) % 10);
            exp_dig[2] = 4'((v / 100) % 10);
            exp_dig[3] = 4'((v / 1000) % 10);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (v < 10)   exp_dig[1] = 4'hF;
            if (v < 100)  exp_dig[2] = 4'hF;
            if (v < 1000) exp_dig[3] = 4'hF;
`endif
        end
    endfunction

    function automatic logic [1:0] exp_sel();
        return 2'((n_edges / SCAN_DIV) % 4);
    endfunction

    // Driver tasks
    // Leaves the bench at the falling edge of cycle 1, where busy should be high.
    task automatic drive_load(input int v);
        @(negedge clk);
        value_in = 14'(v);
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Advance while busy is high, bounded. The count is the number of busy samples.
    task automatic wait_idle(output int busy_cycles);
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    // Tests
    task automatic test_reset();
        logic [1:0] s;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) exp_dig[i] = 4'h0;
        exp_ovf = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL reset_an: got %b want 1110", an); end
        checks++; if (digit_code !== 4'h0) begin errors++; $display("FAIL reset_code: got %h want 0", digit_code); end
        checks++; if (digit_sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", digit_sel); end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            s = exp_sel();
            checks++; if (an !== ~(4'b0001 << s)) begin errors++; $display("FAIL reset_scan_an n=%0d: got %b want %b", n_edges, an, ~(4'b0001 << s)); end
            checks++; if (digit_sel !== s) begin errors++; $display("FAIL reset_scan_sel n=%0d: got %0d want %0d", n_edges, digit_sel, s); end
            checks++; if (digit_code !== 4'h0) begin errors++; $display("FAIL reset_scan_code n=%0d: got %h want 0", n_edges, digit_code); end
        end
    endtask

    // Load v and run it to completion. The expected latency is 14 busy cycles.
    // After the commit, the digits are checked across every scan slot.
    task automatic test_convert(input string tag, input int v);
        int bc;
        logic [1:0] s;
        drive_load(v);
        model_commit(v);
        wait_idle(bc);
        checks++; if (bc != 14) begin errors++; $display("FAIL %s busy_len: got %0d want 14", tag, bc); end
        checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL %s overflow: got %b want %b", tag, overflow, exp_ovf); end
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            s = exp_sel();
            checks++; if (digit_code !== exp_dig[s]) begin errors++; $display("FAIL %s code v=%0d slot %0d: got %h want %h", tag, v, s, digit_code, exp_dig[s]); end
            checks++; if (an !== ~(4'b0001 << s)) begin errors++; $display("FAIL %s an slot %0d: got %b want %b", tag, s, an, ~(4'b0001 << s)); end
            @(negedge clk);
        end
    endtask

    task automatic test_ignored_load();
        int bc;
        logic [1:0] s;
        drive_load(1234);
        model_commit(1234);
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignored_busy_c5: got %b want 1", busy); end
        value_in = 14'd8888;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        wait_idle(bc);
        checks++; if (bc != 9) begin errors++; $display("FAIL ignored_busy_len: got %0d want 9 remaining", bc); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ignored_overflow: got %b want 0", overflow); end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored_no_requeue: got %b want 0", busy); end
        for (int k = 0; k < 16; k++) begin
            s = exp_sel();
            checks++; if (digit_code !== exp_dig[s]) begin errors++; $display("FAIL ignored_code slot %0d: got %h want %h", s, digit_code, exp_dig[s]); end
            @(negedge clk);
        end
        test_convert("after_ignored", 8888);
    endtask

    task automatic test_back_to_back();
        int bc;
        logic [1:0] s;
        drive_load(777);
        model_commit(777);
        wait_idle(bc);
        checks++; if (bc != 14) begin errors++; $display("FAIL b2b_first_len: got %0d want 14", bc); end
        // Load in the very cycle busy falls. The FSM is idle and must accept it.
        value_in = 14'd3050;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b want 1", busy); end
        model_commit(3050);
        wait_idle(bc);
        checks++; if (bc != 14) begin errors++; $display("FAIL b2b_second_len: got %0d want 14", bc); end
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            s = exp_sel();
            checks++; if (digit_code !== exp_dig[s]) begin errors++; $display("FAIL b2b_code slot %0d: got %h want %h", s, digit_code, exp_dig[s]); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_convert();
        logic [1:0] s;
        drive_load(5678);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) exp_dig[i] = 4'h0;
        exp_ovf = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (digit_code !== 4'h0) begin errors++; $display("FAIL midrst_code: got %h want 0", digit_code); end
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL midrst_an: got %b want 1110", an); end
        rst_n = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            s = exp_sel();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_after k=%0d: got %b want 0", k, busy); end
            checks++; if (digit_code !== exp_dig[s] || overflow !== exp_ovf) begin errors++; $display("FAIL midrst_no_commit slot %0d: got code %h ovf %b want %h %b", s, digit_code, overflow, exp_dig[s], exp_ovf); end
        end
    endtask

    task automatic test_random();
        int v;
        for (int i = 0; i < 10; i++) begin
            v = (i % 3 == 2) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 9999));
            test_convert("random", v);
        end
    endtask

    initial begin
        test_reset();
        test_convert("v1234", 1234);
        test_convert("v9999", 9999);
        test_convert("v12000", 12000);
        test_ignored_load();
        test_reset_mid_convert();
        test_convert("v42", 42);
        test_convert("v0", 0);
        test_convert("v16383", 16383);
        test_convert("v10000", 10000);
        test_convert("v7", 7);
        test_convert("v305", 305);
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
